// File: rtl/proto_rst_seq_ctrl.sv
// proto_rst_seq_ctrl: reset / clock bring-up sequencer for the prototype top.
// The MMCM is held in reset, then the design waits for lock and checks that it
// stays stable. After that the subsystem resets are released one stage at a time,
// bit 0 first. Lock loss or a software request starts the sequence again.
module proto_rst_seq_ctrl #(
  parameter int unsigned NUM_STAGES       = 4,
  parameter int unsigned MMCM_RST_CYC     = 64,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned STAGE_GAP_CYC    = 64
) (
  input  logic                  i_fpga_clk,
  input  logic                  i_rst,
  input  logic                  i_mmcm_locked,
  input  logic                  i_sw_rst_req,
  output logic                  o_mmcm_rst,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_all_ready,
  output logic [2:0]            o_state,
  output logic [7:0]            o_relock_cnt
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = max_u(max_u(MMCM_RST_CYC, LOCK_TIMEOUT_CYC),
                                          max_u(LOCK_STABLE_CYC, STAGE_GAP_CYC));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mmcm_rst_q, mmcm_rst_d;
  logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic                    all_ready_q, all_ready_d;
  logic [7:0]              relock_q, relock_d;
  logic                    relock_inc;
  logic                    lock_meta, lock_sync;

  // Two-flop synchronizer for the asynchronous MMCM lock indication.
  always_ff @(posedge i_fpga_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= i_mmcm_locked;
      lock_sync <= lock_meta;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_fpga_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_MMCM_RST;
      cnt_q       <= '0;
      mmcm_rst_q  <= 1'b1;
      stage_rst_q <= '1;
      all_ready_q <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mmcm_rst_q  <= mmcm_rst_d;
      stage_rst_q <= stage_rst_d;
      all_ready_q <= all_ready_d;
      relock_q    <= relock_d;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mmcm_rst_d  = mmcm_rst_q;
    stage_rst_d = stage_rst_q;
    all_ready_d = all_ready_q;
    relock_inc  = 1'b0;

    case (state_q)
      ST_MMCM_RST: begin
        mmcm_rst_d  = 1'b1;
        stage_rst_d = '1;
        all_ready_d = 1'b0;
        if (cnt_q == MMCM_LAST) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          mmcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        mmcm_rst_d = 1'b0;
        if (lock_sync) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_MMCM_RST;
          cnt_d      = '0;
          mmcm_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STABLE: begin
        if (!lock_sync) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          relock_inc = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          // Every entry into STABLE leaves all bits set, so this shift clears only bit 0.
          state_d     = ST_RELEASE;
          cnt_d       = '0;
          stage_rst_d = stage_rst_q << 1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!lock_sync) begin
          state_d     = ST_WAIT_LOCK;
          cnt_d       = '0;
          stage_rst_d = '1;
          all_ready_d = 1'b0;
          relock_inc  = 1'b1;
        end else if (i_sw_rst_req) begin
          state_d     = ST_STABLE;
          cnt_d       = '0;
          stage_rst_d = '1;
          all_ready_d = 1'b0;
        end else if (stage_rst_q == '0) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          all_ready_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          // Shifting in zeros from the LSB clears the stages strictly in bit order.
          cnt_d       = '0;
          stage_rst_d = stage_rst_q << 1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_sync) begin
          state_d     = ST_WAIT_LOCK;
          cnt_d       = '0;
          stage_rst_d = '1;
          all_ready_d = 1'b0;
          relock_inc  = 1'b1;
        end else if (i_sw_rst_req) begin
          state_d     = ST_STABLE;
          cnt_d       = '0;
          stage_rst_d = '1;
          all_ready_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_MMCM_RST;
        cnt_d       = '0;
        mmcm_rst_d  = 1'b1;
        stage_rst_d = '1;
        all_ready_d = 1'b0;
      end
    endcase

    relock_d = (relock_inc && (relock_q != 8'hFF)) ? relock_q + 8'd1 : relock_q;
  end

  assign o_mmcm_rst   = mmcm_rst_q;
  assign o_stage_rst  = stage_rst_q;
  assign o_all_ready  = all_ready_q;
  assign o_state      = state_q;
  assign o_relock_cnt = relock_q;

endmodule
